// File: rtl/common_gnss_types_pkg.sv
// common_gnss_types_pkg: shared GNSS receiver types, widths and the acquisition FSM state encoding.
package common_gnss_types_pkg;
    localparam int ACC_W  = 16;
    localparam int MAX_SV = 32;
    typedef logic [$clog2(MAX_SV+1)-1:0] sv_t;
    typedef logic [9:0]                  gps_chip_t;
    typedef logic signed [ACC_W-1:0]     acc_t;
    typedef logic [ACC_W:0]              mag_t;
    typedef logic signed [15:0]          doppler_hz_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_REPORT, S_DONE} acq_state_t;
    // Sign-extend before negating so the most negative accumulator value maps to its true magnitude.
    function automatic mag_t abs_acc(input acc_t x);
        return x[ACC_W-1] ? mag_t'(-{x[ACC_W-1], x}) : mag_t'(x);
    endfunction
endpackage

// File: rtl/gnss_mag_abs.sv
// gnss_mag_abs: combinational non-coherent magnitude |I|+|Q|, one bit wider than the accumulators.
import common_gnss_types_pkg::*;
module gnss_mag_abs (
    input  acc_t i,
    input  acc_t q,
    output mag_t mag
);
    assign mag = abs_acc(i) + abs_acc(q);
endmodule

// File: rtl/gnss_acq_scheduler.sv
// gnss_acq_scheduler: cold-start acquisition sequencer driving one shared correlator over SV x Doppler x chip.
// Define ACQ_EARLY_EXIT_EN to abandon an SV as soon as a point exceeds the threshold.
import common_gnss_types_pkg::*;
module gnss_acq_scheduler #(
    parameter int NUM_BINS        = 21,
    parameter int DOPPLER_MIN_HZ  = -5000,
    parameter int DOPPLER_STEP_HZ = 500,
    parameter int NUM_CHIPS       = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  sv_t         sv_first,
    input  sv_t         sv_last,
    input  mag_t        threshold,
    output logic        req_valid,
    input  logic        req_ready,
    output sv_t         req_sv,
    output gps_chip_t   req_chip,
    output doppler_hz_t req_doppler_hz,
    input  logic        corr_valid,
    input  acc_t        corr_i,
    input  acc_t        corr_q,
    output logic        det_valid,
    input  logic        det_ready,
    output sv_t         det_sv,
    output gps_chip_t   det_chip,
    output logic [4:0]  det_bin,
    output mag_t        det_peak,
    output logic        busy,
    output logic        done
);
    localparam gps_chip_t   CHIP_LAST = gps_chip_t'(NUM_CHIPS - 1);
    localparam logic [4:0]  BIN_LAST  = 5'(NUM_BINS - 1);
    localparam doppler_hz_t DOP_MIN   = doppler_hz_t'(DOPPLER_MIN_HZ);
    localparam doppler_hz_t DOP_STEP  = doppler_hz_t'(DOPPLER_STEP_HZ);

    acq_state_t  state_q, state_d;
    sv_t         sv_q, sv_d, sv_last_q, sv_last_d, det_sv_q, det_sv_d;
    mag_t        thr_q, thr_d, peak_q, peak_d, det_peak_q, det_peak_d, mag;
    gps_chip_t   chip_q, chip_d, pk_chip_q, pk_chip_d, det_chip_q, det_chip_d;
    logic [4:0]  bin_q, bin_d, pk_bin_q, pk_bin_d, det_bin_q, det_bin_d;
    doppler_hz_t dop_q, dop_d;
    acc_t        ci_q, ci_d, cq_q, cq_d;
    logic        hit_q, hit_d, req_valid_q, req_valid_d, det_valid_q, det_valid_d;
    logic        done_q, done_d, busy_q, busy_d, enter, sv_end;

    gnss_mag_abs u_mag (.i(ci_q), .q(cq_q), .mag(mag));

    always_comb begin
        state_d     = state_q;
        sv_d        = sv_q;
        sv_last_d   = sv_last_q;
        thr_d       = thr_q;
        chip_d      = chip_q;
        bin_d       = bin_q;
        dop_d       = dop_q;
        peak_d      = peak_q;
        pk_chip_d   = pk_chip_q;
        pk_bin_d    = pk_bin_q;
        hit_d       = hit_q;
        ci_d        = ci_q;
        cq_d        = cq_q;
        req_valid_d = req_valid_q;
        det_valid_d = det_valid_q;
        det_sv_d    = det_sv_q;
        det_chip_d  = det_chip_q;
        det_bin_d   = det_bin_q;
        det_peak_d  = det_peak_q;
        done_d      = 1'b0;
        enter       = 1'b0;
        sv_end      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                sv_d        = sv_first;
                sv_last_d   = sv_last;
                thr_d       = threshold;
                enter       = 1'b1;
                state_d     = (sv_first > sv_last) ? S_DONE : S_ISSUE;
                done_d      = sv_first > sv_last;
                req_valid_d = sv_first <= sv_last;
            end
            S_ISSUE: if (req_ready) begin
                state_d     = S_WAIT;
                req_valid_d = 1'b0;
            end
            S_WAIT: if (corr_valid) begin
                ci_d    = corr_i;
                cq_d    = corr_q;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (mag > peak_q) begin
                    peak_d    = mag;
                    pk_chip_d = chip_q;
                    pk_bin_d  = bin_q;
                    hit_d     = 1'b1;
                end
                chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + 10'd1;
                bin_d  = (chip_q == CHIP_LAST) ? bin_q + 5'd1 : bin_q;
                dop_d  = (chip_q == CHIP_LAST) ? dop_q + DOP_STEP : dop_q;
`ifdef ACQ_EARLY_EXIT_EN
                sv_end = ((chip_q == CHIP_LAST) && (bin_q == BIN_LAST)) || (mag > thr_q);
`else
                sv_end = (chip_q == CHIP_LAST) && (bin_q == BIN_LAST);
`endif
                state_d     = sv_end ? S_REPORT : S_ISSUE;
                req_valid_d = !sv_end;
                det_valid_d = sv_end && hit_d && (peak_d > thr_q);
                det_sv_d    = sv_end ? sv_q : det_sv_q;
                det_chip_d  = sv_end ? pk_chip_d : det_chip_q;
                det_bin_d   = sv_end ? pk_bin_d : det_bin_q;
                det_peak_d  = sv_end ? peak_d : det_peak_q;
            end
            S_REPORT: if (!det_valid_q || det_ready) begin
                det_valid_d = 1'b0;
                state_d     = (sv_q == sv_last_q) ? S_DONE : S_ISSUE;
                done_d      = sv_q == sv_last_q;
                req_valid_d = sv_q != sv_last_q;
                sv_d        = (sv_q == sv_last_q) ? sv_q : sv_q + 6'd1;
                enter       = sv_q != sv_last_q;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter) begin
            chip_d    = '0;
            bin_d     = '0;
            dop_d     = DOP_MIN;
            peak_d    = '0;
            pk_chip_d = '0;
            pk_bin_d  = '0;
            hit_d     = 1'b0;
        end
        // Abort discards any outstanding result: WAIT is left, so a late strobe lands in IDLE.
        if (abort) begin
            state_d     = S_IDLE;
            req_valid_d = 1'b0;
            det_valid_d = 1'b0;
            done_d      = 1'b0;
            chip_d      = '0;
            bin_d       = '0;
            dop_d       = '0;
            peak_d      = '0;
            pk_chip_d   = '0;
            pk_bin_d    = '0;
            hit_d       = 1'b0;
        end
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sv_q        <= '0;
            sv_last_q   <= '0;
            thr_q       <= '0;
            chip_q      <= '0;
            bin_q       <= '0;
            dop_q       <= '0;
            peak_q      <= '0;
            pk_chip_q   <= '0;
            pk_bin_q    <= '0;
            hit_q       <= 1'b0;
            ci_q        <= '0;
            cq_q        <= '0;
            req_valid_q <= 1'b0;
            det_valid_q <= 1'b0;
            det_sv_q    <= '0;
            det_chip_q  <= '0;
            det_bin_q   <= '0;
            det_peak_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sv_q        <= sv_d;
            sv_last_q   <= sv_last_d;
            thr_q       <= thr_d;
            chip_q      <= chip_d;
            bin_q       <= bin_d;
            dop_q       <= dop_d;
            peak_q      <= peak_d;
            pk_chip_q   <= pk_chip_d;
            pk_bin_q    <= pk_bin_d;
            hit_q       <= hit_d;
            ci_q        <= ci_d;
            cq_q        <= cq_d;
            req_valid_q <= req_valid_d;
            det_valid_q <= det_valid_d;
            det_sv_q    <= det_sv_d;
            det_chip_q  <= det_chip_d;
            det_bin_q   <= det_bin_d;
            det_peak_q  <= det_peak_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign req_valid      = req_valid_q;
    assign req_sv         = sv_q;
    assign req_chip       = chip_q;
    assign req_doppler_hz = dop_q;
    assign det_valid      = det_valid_q;
    assign det_sv         = det_sv_q;
    assign det_chip       = det_chip_q;
    assign det_bin        = det_bin_q;
    assign det_peak       = det_peak_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_gnss_acq_scheduler.sv
// tb_gnss_acq_scheduler: directed bench; a full-size instance for the full sweep, a 2x3 instance for corner cases.
import common_gnss_types_pkg::*;
module tb_gnss_acq_scheduler;
    localparam int SB = 2, SC = 3;
    logic clk = 1'b0, rst = 1'b1, abort = 1'b0, det_ready = 1'b1;
    sv_t  sv_first = '0, sv_last = '0;
    mag_t threshold = '0;
    always #5 clk = ~clk;

    logic b_start = 1'b0, b_req_ready = 1'b1, b_cv = 1'b0;
    acc_t b_ci = '0, b_cq = '0;
    logic b_req_valid, b_det_valid, b_busy, b_done;
    sv_t b_req_sv, b_det_sv;
    gps_chip_t b_req_chip, b_det_chip;
    doppler_hz_t b_req_dop;
    logic [4:0] b_det_bin;
    mag_t b_det_peak;
    int b_nreq = 0, b_ndone = 0;

    logic s_start = 1'b0, s_req_ready = 1'b1, s_mcv = 1'b0, s_xcv = 1'b0, s_mdl_en = 1'b1, s_cv;
    acc_t s_mi = '0, s_mq = '0, s_xi = '0, s_xq = '0, s_ci, s_cq;
    acc_t sp_i = 16'sd1000, sp_q = -16'sd200;
    sv_t sp_sv = 6'd5;
    gps_chip_t sp_chip = 10'd2;
    doppler_hz_t sp_dop = -16'sd4500;
    logic s_req_valid, s_det_valid, s_busy, s_done;
    sv_t s_req_sv, s_det_sv, e_sv = '0;
    gps_chip_t s_req_chip, s_det_chip, e_chip = '0;
    doppler_hz_t s_req_dop, e_dop = '0;
    logic [4:0] s_det_bin, e_bin = '0;
    mag_t s_det_peak;
    int s_nreq = 0, s_nrep = 0, s_ndone = 0, s_oerr = 0;
    int nrun = 0, nfail = 0;

    assign s_cv = s_mcv | s_xcv;
    assign s_ci = s_xcv ? s_xi : s_mi;
    assign s_cq = s_xcv ? s_xq : s_mq;

    gnss_acq_scheduler u_big (
        .clk(clk), .rst(rst), .start(b_start), .abort(abort), .sv_first(sv_first), .sv_last(sv_last),
        .threshold(threshold), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sv(b_req_sv),
        .req_chip(b_req_chip), .req_doppler_hz(b_req_dop), .corr_valid(b_cv), .corr_i(b_ci), .corr_q(b_cq),
        .det_valid(b_det_valid), .det_ready(det_ready), .det_sv(b_det_sv), .det_chip(b_det_chip),
        .det_bin(b_det_bin), .det_peak(b_det_peak), .busy(b_busy), .done(b_done)
    );

    gnss_acq_scheduler #(.NUM_BINS(SB), .NUM_CHIPS(SC)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(abort), .sv_first(sv_first), .sv_last(sv_last),
        .threshold(threshold), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_sv(s_req_sv),
        .req_chip(s_req_chip), .req_doppler_hz(s_req_dop), .corr_valid(s_cv), .corr_i(s_ci), .corr_q(s_cq),
        .det_valid(s_det_valid), .det_ready(det_ready), .det_sv(s_det_sv), .det_chip(s_det_chip),
        .det_bin(s_det_bin), .det_peak(s_det_peak), .busy(s_busy), .done(s_done)
    );

    // Full-size correlator: one strong point at SV5, 1000 Hz (bin 12), chip 300.
    always @(posedge clk) begin
        b_cv <= b_req_valid && b_req_ready;
        if (b_req_valid && b_req_ready) begin
            b_nreq <= b_nreq + 1;
            b_ci <= (b_req_sv == 6'd5 && b_req_chip == 10'd300 && b_req_dop == 16'sd1000) ? 16'sd1000 : 16'sd0;
            b_cq <= (b_req_sv == 6'd5 && b_req_chip == 10'd300 && b_req_dop == 16'sd1000) ? -16'sd200 : 16'sd0;
        end
        if (b_done) b_ndone <= b_ndone + 1;
    end

    // Small correlator plus an independent tracker of the point order the sweep must follow.
    always @(posedge clk) begin
        s_mcv <= s_req_valid && s_req_ready && s_mdl_en;
        if (s_req_valid && s_req_ready) begin
            s_nreq <= s_nreq + 1;
            if (s_req_sv != e_sv || s_req_chip != e_chip || s_req_dop != e_dop) s_oerr <= s_oerr + 1;
            e_chip <= (e_chip == SC - 1) ? 10'd0 : e_chip + 10'd1;
            if (e_chip == SC - 1) begin
                e_bin <= (e_bin == SB - 1) ? 5'd0 : e_bin + 5'd1;
                e_dop <= (e_bin == SB - 1) ? -16'sd5000 : e_dop + 16'sd500;
                e_sv  <= (e_bin == SB - 1) ? e_sv + 6'd1 : e_sv;
            end
            s_mi <= (s_req_sv == sp_sv && s_req_chip == sp_chip && s_req_dop == sp_dop) ? sp_i : 16'sd0;
            s_mq <= (s_req_sv == sp_sv && s_req_chip == sp_chip && s_req_dop == sp_dop) ? sp_q : 16'sd0;
        end
        if (s_start && !s_busy) begin
            e_sv   <= sv_first;
            e_chip <= '0;
            e_bin  <= '0;
            e_dop  <= -16'sd5000;
        end
        if (s_det_valid && det_ready) s_nrep <= s_nrep + 1;
        if (s_done) s_ndone <= s_ndone + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_small(input int f, input int l, input int thr);
        sv_first  = sv_t'(f);
        sv_last   = sv_t'(l);
        threshold = mag_t'(thr);
        s_start   = 1'b1;
        tick();
        s_start   = 1'b0;
    endtask

    task automatic wait_det_s(input string tag, input int maxc);
        int n = 0;
        while (!s_det_valid && n < maxc) begin
            tick();
            n++;
        end
        check(tag, s_det_valid, 1);
    endtask

    task automatic wait_done_s(input string tag, input int maxc);
        int n = 0;
        while (!s_done && n < maxc) begin
            tick();
            n++;
        end
        check(tag, s_done, 1);
        tick();
    endtask

    initial begin
        int r0, p0, d0, bad, n;
        repeat (3) tick();
        check("rst_req_valid", b_req_valid, 0);
        check("rst_busy", b_busy, 0);
        check("rst_done", b_done, 0);
        check("rst_det_valid", b_det_valid, 0);
        check("rst_req_sv", b_req_sv, 0);
        check("rst_req_chip", b_req_chip, 0);
        check("rst_req_dop", $signed(b_req_dop), 0);
        check("rst_det_peak", b_det_peak, 0);
        check("rst_small_busy", s_busy, 0);
        rst = 1'b0;
        tick();

        r0 = s_nreq;
        start_small(3, 2, 0);
        check("empty_done", s_done, 1);
        tick();
        check("empty_done_pulse", s_done, 0);
        check("empty_idle", s_busy, 0);
        check("empty_nreq", s_nreq - r0, 0);

        det_ready = 1'b0;
        r0 = s_nreq; p0 = s_nrep; d0 = s_ndone;
        start_small(4, 5, 1199);
        wait_det_s("det_seen", 100);
        check("det_sv", s_det_sv, 5);
        check("det_bin", s_det_bin, 1);
        check("det_chip", s_det_chip, 2);
        check("det_peak", s_det_peak, 1200);
        repeat (3) tick();
        check("det_hold_valid", s_det_valid, 1);
        check("det_hold_peak", s_det_peak, 1200);
        det_ready = 1'b1;
        wait_done_s("det_done", 20);
        check("det_nrep", s_nrep - p0, 1);
        check("det_nreq", s_nreq - r0, 12);
        check("det_ndone", s_ndone - d0, 1);

        r0 = s_nreq; p0 = s_nrep; d0 = s_ndone;
        start_small(4, 5, 1200);
        wait_done_s("tie_done", 100);
        check("tie_nrep", s_nrep - p0, 0);
        check("tie_ndone", s_ndone - d0, 1);
        check("tie_nreq", s_nreq - r0, 12);

        s_req_ready = 1'b0;
        r0 = s_nreq;
        start_small(1, 1, 1199);
        check("stall_req_n1", s_req_valid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_req_valid || s_req_sv != 6'd1 || s_req_chip != 10'd0 || s_req_dop != -16'sd5000) bad++;
            tick();
        end
        check("stall_stable", bad, 0);
        s_req_ready = 1'b1;
        wait_done_s("stall_done", 50);
        check("stall_nreq", s_nreq - r0, 6);
        check("stall_order", s_oerr, 0);

        sp_sv = 6'd2; sp_chip = 10'd0; sp_dop = -16'sd5000; sp_i = -16'sd32768; sp_q = -16'sd32768;
        r0 = s_nreq;
        start_small(2, 2, 0);
        wait_det_s("min_seen", 50);
        check("min_peak", s_det_peak, 65536);
        check("min_bin", s_det_bin, 0);
        check("min_chip", s_det_chip, 0);
        wait_done_s("min_done", 20);
`ifdef ACQ_EARLY_EXIT_EN
        check("min_nreq", s_nreq - r0, 1);
`else
        check("min_nreq", s_nreq - r0, 6);
`endif

        sp_sv = 6'd5; sp_chip = 10'd2; sp_dop = -16'sd4500; sp_i = 16'sd1000; sp_q = -16'sd200;
        s_mdl_en = 1'b0;
        start_small(4, 5, 1199);
        repeat (3) tick();
        check("abort_in_wait", s_busy && !s_req_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", s_busy, 0);
        check("abort_req_valid", s_req_valid, 0);
        s_xi = 16'sd1000; s_xq = 16'sd0; s_xcv = 1'b1;
        tick();
        s_xcv = 1'b0;
        tick();
        check("late_busy", s_busy, 0);
        check("late_req_valid", s_req_valid, 0);
        check("late_det_valid", s_det_valid, 0);
        s_mdl_en = 1'b1;
        r0 = s_nreq; p0 = s_nrep;
        start_small(5, 5, 1199);
        check("restart_sv", s_req_sv, 5);
        check("restart_chip", s_req_chip, 0);
        check("restart_dop", $signed(s_req_dop), -5000);
        wait_det_s("restart_det", 50);
        check("restart_peak", s_det_peak, 1200);
        wait_done_s("restart_done", 20);
        check("restart_nreq", s_nreq - r0, 6);
        check("restart_nrep", s_nrep - p0, 1);
        check("restart_order", s_oerr, 0);

        r0 = s_nreq;
        start_small(1, 2, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", s_busy, 0);
        check("async_rst_req_valid", s_req_valid, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("async_rst_nreq", s_nreq - r0, 0);

        sv_first = 6'd5; sv_last = 6'd5; threshold = 17'd500;
        d0 = b_ndone;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (!b_det_valid && n < 70000) begin
            tick();
            n++;
        end
        check("big_det_seen", b_det_valid, 1);
        check("big_det_sv", b_det_sv, 5);
        check("big_det_bin", b_det_bin, 12);
        check("big_det_chip", b_det_chip, 300);
        check("big_det_peak", b_det_peak, 1200);
`ifdef ACQ_EARLY_EXIT_EN
        check("big_nreq", b_nreq, 12 * 1023 + 301);
`else
        check("big_nreq", b_nreq, 21483);
`endif
        n = 0;
        while (!b_done && n < 10) begin
            tick();
            n++;
        end
        check("big_done", b_done, 1);
        tick();
        check("big_ndone", b_ndone - d0, 1);
        check("big_idle", b_busy, 0);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
